// File: rtl/mul16_seq_pkg.sv
// Shared definitions for adder-reusing arithmetic sequencers (multiply now,
// divide and multiply-accumulate later): state encodings and iteration count.
// Purely declarative; no logic lives here.
package mul16_seq_pkg;

  // Operand width of the shared adder.
  localparam int SEQ_WIDTH = 16;

  // Number of shift-and-add iterations per operation.
  localparam int SEQ_ITER = 16;

  // Width of the iteration counter; the counter wraps naturally after the last step.
  localparam int SEQ_CNT_W = $clog2(SEQ_ITER);

  // Sequencer states. Encoding 2'd3 is illegal and decodes to IDLE.
  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/mul16_seq_add16.sv
// ADD16: combinational 16-bit modulo-2^16 adder. The carry out is discarded,
// giving plain two's-complement wraparound. This is the only adder in the sequencer.
module mul16_seq_add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/mul16_seq.sv
// Sequential 16x16 multiplier returning the low 16 bits of the product.
// It runs 16 shift-and-add steps through one shared ADD16, so every operation
// takes 17 edges from accept to done. A new start is taken in IDLE or DONE.
module mul16_seq
  import mul16_seq_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH,
  parameter int ITER  = SEQ_ITER
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  seq_state_t state;
  seq_state_t state_nxt;

  logic [WIDTH-1:0]     acc;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplier;
  logic [SEQ_CNT_W-1:0] cnt;

  logic [WIDTH-1:0] add_sum;
  logic [WIDTH-1:0] acc_iter;
  logic             accept;
  logic             last;

  // The single shared adder: the running sum plus the shifted multiplicand.
  mul16_seq_add16 u_add16 (
    .a   (acc),
    .b   (mcand),
    .sum (add_sum)
  );

  // The accumulator picks up the partial product only when the current multiplier bit is set.
  assign acc_iter = mplier[0] ? add_sum : acc;

  // Busy and done are decoded directly from state, so reset clears them without waiting for an edge.
  assign busy = (state == SEQ_RUN);
  assign done = (state == SEQ_DONE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SEQ_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode, plus the accept and last-iteration strobes for the datapath.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      SEQ_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SEQ_RUN;
        end
      end
      SEQ_RUN: begin
        // A start seen here is dropped: there is no queue behind the sequencer.
        if (cnt == SEQ_CNT_W'(ITER - 1)) begin
          last      = 1'b1;
          state_nxt = SEQ_DONE;
        end
      end
      SEQ_DONE: begin
        // The done cycle also acts as the accept slot for back-to-back operations.
        if (start) begin
          accept    = 1'b1;
          state_nxt = SEQ_RUN;
        end else begin
          state_nxt = SEQ_IDLE;
        end
      end
      default: begin
        state_nxt = SEQ_IDLE;
      end
    endcase
  end

  // Datapath: load the operands on accept, then shift and accumulate once per RUN cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (accept) begin
      acc    <= '0;
      mcand  <= A;
      mplier <= B;
      cnt    <= '0;
    end else if (state == SEQ_RUN) begin
      acc    <= acc_iter;
      mcand  <= {mcand[WIDTH-2:0], 1'b0};
      mplier <= {1'b0, mplier[WIDTH-1:1]};
      cnt    <= cnt + 1'b1;
    end
  end

  // The result register updates only on the final iteration and otherwise holds through DONE and IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      product <= '0;
    end else if (last) begin
      product <= acc_iter;
    end
  end

endmodule

// File: tb/tb_mul16_seq.sv
// Bench for mul16_seq: directed corner cases, then random operands, all
// compared against the arithmetic product modulo 2^16 and against fixed
// busy/done timing.
module tb_mul16_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int total = 0;
  int bad   = 0;

  mul16_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the true product, truncated to 16 bits.
  function automatic logic [15:0] model_mul(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] full;
    full = 32'(a) * 32'(b);
    return full[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge just after the accept edge. Counts RUN cycles and
  // returns at the first negedge where busy is low. When inject_at is reached,
  // it drives a start with fresh operands for one cycle; the DUT must ignore it.
  task automatic count_busy(input int inject_at, output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (n == inject_at) begin
        start = 1'b1;
        A = 16'($urandom);
        B = 16'($urandom);
      end else if (n == inject_at + 1) begin
        start = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  // One full operation, started from a negedge, ending one cycle after done.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input int inject_at);
    int n;
    logic [15:0] exp;
    exp   = model_mul(a, b);
    A     = a;
    B     = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = 16'($urandom);
    B = 16'($urandom);
    count_busy(inject_at, n);
    chk({tag, ".busy_cycles"}, n, 16);
    chk({tag, ".done"}, done, 1);
    chk({tag, ".product"}, product, exp);
    @(negedge clk);
    chk({tag, ".done_once"}, done, 0);
    chk({tag, ".idle_busy"}, busy, 0);
    chk({tag, ".held"}, product, exp);
  endtask

  initial begin
    int n;
    int done_seen;
    logic [15:0] ra;
    logic [15:0] rb;

    reset = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (2) @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.product", product, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle.busy", busy, 0);

    // Directed corner cases.
    do_op("d3x5", 16'h0003, 16'h0005, -1);
    do_op("dffff", 16'hFFFF, 16'hFFFF, -1);
    do_op("d00ff", 16'h00FF, 16'h0101, -1);
    do_op("dzero", 16'h1234, 16'h0000, -1);
    do_op("dinj", 16'h1234, 16'h0010, 5);

    // Back-to-back with start held high the whole time.
    A = 16'h0002;
    B = 16'h0003;
    start = 1'b1;
    @(negedge clk);
    A = 16'($urandom);
    B = 16'($urandom);
    count_busy(-1, n);
    chk("b2b1.busy_cycles", n, 16);
    chk("b2b1.done", done, 1);
    chk("b2b1.product", product, 16'h0006);
    A = 16'h0004;
    B = 16'h0004;
    @(negedge clk);
    chk("b2b2.no_idle", busy, 1);
    chk("b2b2.done_low", done, 0);
    start = 1'b0;
    A = 16'($urandom);
    B = 16'($urandom);
    count_busy(-1, n);
    chk("b2b2.busy_cycles", n, 16);
    chk("b2b2.done", done, 1);
    chk("b2b2.product", product, 16'h0010);
    @(negedge clk);
    chk("b2b2.idle", done | busy, 0);

    // Asynchronous reset in the middle of an operation.
    A = 16'h0007;
    B = 16'h0009;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst.busy", busy, 0);
    chk("arst.done", done, 0);
    chk("arst.product", product, 0);
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("arst.no_done", done_seen, 0);
    do_op("arst.rerun", 16'h0007, 16'h0009, -1);

    // Random operands, some with an ignored mid-RUN start.
    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 6 == 0) rb = 16'(1) << (i % 16);
      do_op($sformatf("rnd%0d", i), ra, rb, (i % 3 == 0) ? int'($urandom_range(1, 14)) : -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
